// File: rtl/digit_sequencer.sv
// rtl/digit_sequencer.sv - push-button driven 1..8 digit sequencer with auto-advance
//
// Purpose: debounces two raw push-buttons, advances a displayed digit 1..8
//          on each "next" press or periodic auto tick, and blanks the
//          display on a "clear" press.
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   btn_next   raw push-button, advance digit
//   btn_clear  raw push-button, blank display
//   auto_en    level, enables periodic auto-advance while showing
//   num        registered 7-segment code: 1001..1111 = 1..7, 1000 = 8, 0000 = blank
//   value      registered binary digit 1..8, 0 when blank
//   wrap       one-cycle pulse when the digit advances from 8 to 1
module digit_sequencer #(
   parameter int DEB_CYCLES = 1_000_000,
   parameter int TICK_DIV   = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_clear,
   input  logic       auto_en,
   output logic [3:0] num,
   output logic [3:0] value,
   output logic       wrap
);

   localparam int DW = $clog2(DEB_CYCLES);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
   localparam logic [DW-1:0] D_ONE   = DW'(1);
   localparam logic [PW-1:0] P_MAX   = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] P_ONE   = PW'(1);

   typedef enum logic {BLANK, SHOW} state_t;

   // Button lanes: bit 0 = next, bit 1 = clear.
   logic [1:0]    sync1, sync2, deb, deb_q;
   logic [DW-1:0] cnt [2];
   logic [1:0]    press;

   state_t        state_q, state_d;
   logic [3:0]    value_q, value_d;
   logic [3:0]    num_q, num_d;
   logic          wrap_q, wrap_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
   logic          next_p, clear_p;

   // Synchronizers and debouncers. The debounced level only flips after
   // DEB_CYCLES consecutive mismatching cycles; any agreeing cycle restarts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         deb    <= '0;
         deb_q  <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= {btn_clear, btn_next};
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != deb[i]) begin
               if (cnt[i] == DEB_MAX) begin
                  deb[i] <= sync2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + D_ONE;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // Rising edge of the debounced level only; releases produce nothing.
   assign press   = deb & ~deb_q;
   assign next_p  = press[0];
   assign clear_p = press[1];

   assign tick = (state_q == SHOW) && auto_en && (presc_q == P_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BLANK;
         value_q <= '0;
         num_q   <= '0;
         wrap_q  <= 1'b0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         num_q   <= num_d;
         wrap_q  <= wrap_d;
         presc_q <= presc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      presc_d = '0;
      wrap_d  = 1'b0;
      case (state_q)
         BLANK: begin
            if (next_p) begin
               state_d = SHOW;
               value_d = 4'd1;
            end
         end
         SHOW: begin
            if (clear_p) begin
               // Clear has priority over any coincident next press or tick.
               state_d = BLANK;
               value_d = 4'd0;
            end else begin
               if (auto_en && !tick && !next_p) begin
                  presc_d = presc_q + P_ONE;
               end
               // Next and tick together still produce a single step.
               if (next_p || tick) begin
                  if (value_q == 4'd8) begin
                     value_d = 4'd1;
                     wrap_d  = 1'b1;
                  end else begin
                     value_d = value_q + 4'd1;
                  end
               end
            end
         end
         default: begin
            state_d = BLANK;
            value_d = 4'd0;
         end
      endcase
      num_d = (state_d == SHOW) ? {1'b1, value_d[2:0]} : 4'b0000;
   end

   assign num   = num_q;
   assign value = value_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// tb/tb_digit_sequencer.sv - self-checking bench for digit_sequencer
module tb_digit_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_next = 1'b0;
   logic       btn_clear = 1'b0;
   logic       auto_en = 1'b0;
   logic [3:0] num;
   logic [3:0] value;
   logic       wrap;

   int checks = 0;
   int failures = 0;
   int wrap_cnt = 0;

   always #5 clk = ~clk;

   digit_sequencer #(.DEB_CYCLES(4), .TICK_DIV(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_next  (btn_next),
      .btn_clear (btn_clear),
      .auto_en   (auto_en),
      .num       (num),
      .value     (value),
      .wrap      (wrap)
   );

   always @(negedge clk) if (wrap === 1'b1) wrap_cnt++;

   typedef struct {
      logic       nxt;
      logic       clr;
      int         hold;
      logic [3:0] exp_num;
      logic [3:0] exp_val;
      int         exp_wraps;
   } vec_t;

   vec_t tbl [21];

   task automatic chk(input string name, input logic [3:0] en, input logic [3:0] ev);
      checks++;
      if (num !== en || value !== ev) begin
         failures++;
         $display("FAIL %s: num=%b value=%0d, expected num=%b value=%0d", name, num, value, en, ev);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      int w0;
      w0 = wrap_cnt;
      @(negedge clk);
      btn_next  = v.nxt;
      btn_clear = v.clr;
      repeat (v.hold) @(negedge clk);
      btn_next  = 1'b0;
      btn_clear = 1'b0;
      repeat (10) @(negedge clk);
      chk($sformatf("vec%0d", idx), v.exp_num, v.exp_val);
      chk_int($sformatf("vec%0d_wraps", idx), wrap_cnt - w0, v.exp_wraps);
   endtask

   initial begin
      vec_t v;
      int   w0;

      tbl[0]  = '{1'b1, 1'b0, 5, 4'b1010, 4'd2, 0};
      tbl[1]  = '{1'b1, 1'b0, 5, 4'b1011, 4'd3, 0};
      tbl[2]  = '{1'b1, 1'b0, 5, 4'b1100, 4'd4, 0};
      tbl[3]  = '{1'b1, 1'b0, 5, 4'b1101, 4'd5, 0};
      tbl[4]  = '{1'b1, 1'b0, 5, 4'b1110, 4'd6, 0};
      tbl[5]  = '{1'b1, 1'b0, 5, 4'b1111, 4'd7, 0};
      tbl[6]  = '{1'b1, 1'b0, 5, 4'b1000, 4'd8, 0};
      tbl[7]  = '{1'b1, 1'b0, 5, 4'b1001, 4'd1, 1};
      tbl[8]  = '{1'b1, 1'b0, 4, 4'b1010, 4'd2, 0};   // minimum accepted hold
      tbl[9]  = '{1'b1, 1'b0, 2, 4'b1010, 4'd2, 0};   // too short, rejected
      tbl[10] = '{1'b0, 1'b1, 5, 4'b0000, 4'd0, 0};   // clear
      tbl[11] = '{1'b0, 1'b1, 5, 4'b0000, 4'd0, 0};   // clear ignored in BLANK
      tbl[12] = '{1'b1, 1'b0, 5, 4'b1001, 4'd1, 0};
      tbl[13] = '{1'b1, 1'b0, 5, 4'b1010, 4'd2, 0};
      tbl[14] = '{1'b1, 1'b0, 5, 4'b1011, 4'd3, 0};
      tbl[15] = '{1'b1, 1'b0, 5, 4'b1100, 4'd4, 0};
      tbl[16] = '{1'b1, 1'b0, 5, 4'b1101, 4'd5, 0};
      tbl[17] = '{1'b1, 1'b1, 5, 4'b0000, 4'd0, 0};   // clear beats next at value 5
      tbl[18] = '{1'b1, 1'b0, 5, 4'b1001, 4'd1, 0};
      tbl[19] = '{1'b1, 1'b0, 5, 4'b1010, 4'd2, 0};
      tbl[20] = '{1'b1, 1'b0, 5, 4'b1011, 4'd3, 0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_state", 4'b0000, 4'd0);
      chk_int("reset_wrap", int'(wrap), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // First press latency: raw rise -> display change after exactly 7 edges
      btn_next = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (k == 6) chk("latency_edge6", 4'b0000, 4'd0);
         if (k == 7) chk("latency_edge7", 4'b1001, 4'd1);
      end
      repeat (3) @(negedge clk);
      btn_next = 1'b0;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 21; i++) apply(tbl[i], i);

      // Bouncing 1-cycle pulses for 20 cycles: no change
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         btn_next = (i % 2 == 0);
      end
      @(negedge clk);
      btn_next = 1'b0;
      repeat (12) @(negedge clk);
      chk("bounce_ignored", 4'b1011, 4'd3);

      // Auto-advance from 3: ticks on edges 10, 20, 30
      auto_en = 1'b1;
      for (int k = 1; k <= 35; k++) begin
         @(posedge clk); #1;
         if (k == 9)  chk("auto_edge9", 4'b1011, 4'd3);
         if (k == 10) chk("auto_edge10", 4'b1100, 4'd4);
         if (k == 20) chk("auto_edge20", 4'b1101, 4'd5);
         if (k == 30) chk("auto_edge30", 4'b1110, 4'd6);
      end
      @(negedge clk);
      chk("auto_35", 4'b1110, 4'd6);
      auto_en = 1'b0;
      repeat (30) @(negedge clk);
      chk("auto_frozen", 4'b1110, 4'd6);

      // auto_en drop mid-period restarts a full period
      auto_en = 1'b1;
      repeat (5) @(negedge clk);
      auto_en = 1'b0;
      @(negedge clk);
      auto_en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 9)  chk("reen_edge9", 4'b1110, 4'd6);
         if (k == 10) chk("reen_edge10", 4'b1111, 4'd7);
      end
      @(negedge clk);

      // Reset mid-period at value 7 with auto_en high
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_reset", 4'b0000, 4'd0);
      chk_int("async_reset_wrap", int'(wrap), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      w0 = wrap_cnt;
      repeat (25) @(negedge clk);
      chk("no_tick_after_reset", 4'b0000, 4'd0);
      auto_en = 1'b0;
      v = '{1'b1, 1'b0, 5, 4'b1001, 4'd1, 0};
      apply(v, 100);
      chk_int("no_wrap_after_reset", wrap_cnt - w0, 0);

      // Button held through reset release: one press after DEB_CYCLES+2 edges
      @(negedge clk);
      btn_next = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("held_in_reset", 4'b0000, 4'd0);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (k == 6) chk("held_edge6", 4'b0000, 4'd0);
         if (k == 7) chk("held_edge7", 4'b1001, 4'd1);
      end
      repeat (10) @(negedge clk);
      chk("held_single", 4'b1001, 4'd1);
      btn_next = 1'b0;
      repeat (10) @(negedge clk);
      chk("held_release", 4'b1001, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
